// File: rtl/trigger_holdoff_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : trigger_holdoff_ctrl_pkg
// Brief   : Shared widths and FSM state encoding for the trigger/holdoff block
// Revision: 1.0
// ============================================================================
package trigger_holdoff_ctrl_pkg;

    localparam int TRIG_NUM_CH       = 8;
    localparam int TRIG_HOLDOFF_BITS = 16;

    typedef enum logic [1:0] {
        TS_IDLE    = 2'd0,
        TS_ARMED   = 2'd1,
        TS_HOLDOFF = 2'd2,
        TS_STOPPED = 2'd3
    } trig_state_t;

endpackage
`default_nettype wire

// File: rtl/trigger_holdoff_ctrl_match.sv
`default_nettype none
// ============================================================================
// Module  : trigger_match
// Brief   : Per-channel masked level/edge compare with one cycle of probe history
// Revision: 1.0
// ============================================================================
module trigger_match
    import trigger_holdoff_ctrl_pkg::*;
#(
    parameter int NUM_CH = TRIG_NUM_CH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] i_data,
    input  logic [NUM_CH-1:0] i_mask,
    input  logic [NUM_CH-1:0] i_value,
    input  logic [NUM_CH-1:0] i_edge_en,
    output logic              match
);

    logic [NUM_CH-1:0] prev_data;
    logic              prev_valid;
    logic [NUM_CH-1:0] edge_hit;
    logic [NUM_CH-1:0] level_hit;
    logic [NUM_CH-1:0] hit;

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_data  <= '0;
            prev_valid <= 1'b0;
        end else begin
            prev_data  <= i_data;
            prev_valid <= 1'b1;
        end
    end

    // Edge terms stay quiet until prev_data holds a real post-reset sample.
    assign edge_hit  = {NUM_CH{prev_valid}} &
                       (( i_value & ~prev_data &  i_data) |
                        (~i_value &  prev_data & ~i_data));
    assign level_hit = ~(i_data ^ i_value);
    assign hit       = (i_edge_en & edge_hit) | (~i_edge_en & level_hit);
    assign match     = &(~i_mask | hit);

endmodule
`default_nettype wire

// File: rtl/trigger_holdoff_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : trigger_holdoff_ctrl
// Brief   : Trigger qualification FSM with latched post-trigger holdoff counter
// Revision: 1.0
// ============================================================================
module trigger_holdoff_ctrl
    import trigger_holdoff_ctrl_pkg::*;
#(
    parameter int NUM_CH        = TRIG_NUM_CH,
    parameter int HOLDOFF_WIDTH = TRIG_HOLDOFF_BITS
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     primed,
    input  logic [NUM_CH-1:0]        i_data,
    input  logic [NUM_CH-1:0]        i_mask,
    input  logic [NUM_CH-1:0]        i_value,
    input  logic [NUM_CH-1:0]        i_edge_en,
    input  logic                     i_force,
    input  logic [HOLDOFF_WIDTH-1:0] i_holdoff,
    input  logic                     i_arm,
    output logic                     triggered,
    output logic                     stopped,
    output logic [1:0]               o_state,
    output logic [HOLDOFF_WIDTH-1:0] o_holdoff_cnt
);

    trig_state_t              state;
    logic [HOLDOFF_WIDTH-1:0] holdoff_lat;
    logic [HOLDOFF_WIDTH-1:0] cnt;
    logic                     match;
    logic                     fire;

    trigger_match #(
        .NUM_CH (NUM_CH)
    ) u_match (
        .clk       (clk),
        .reset     (reset),
        .i_data    (i_data),
        .i_mask    (i_mask),
        .i_value   (i_value),
        .i_edge_en (i_edge_en),
        .match     (match)
    );

    assign fire = match | i_force;

    // Counter stops at the latched value, so the all-ones holdoff never wraps.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= TS_IDLE;
            triggered   <= 1'b0;
            stopped     <= 1'b0;
            cnt         <= '0;
            holdoff_lat <= '0;
        end else begin
            case (state)
                TS_IDLE: begin
                    if (primed) state <= TS_ARMED;
                end
                TS_ARMED: begin
                    if (!primed) begin
                        state <= TS_IDLE;
                    end else if (fire) begin
                        state       <= TS_HOLDOFF;
                        holdoff_lat <= i_holdoff;
                        cnt         <= '0;
                        triggered   <= 1'b1;
                    end
                end
                TS_HOLDOFF: begin
                    if (cnt == holdoff_lat) begin
                        state   <= TS_STOPPED;
                        stopped <= 1'b1;
                    end else begin
                        cnt <= cnt + HOLDOFF_WIDTH'(1);
                    end
                end
                TS_STOPPED: begin
                    if (i_arm) begin
                        state     <= TS_IDLE;
                        cnt       <= '0;
                        triggered <= 1'b0;
                        stopped   <= 1'b0;
                    end
                end
                default: state <= TS_IDLE;
            endcase
        end
    end

    assign o_state       = state;
    assign o_holdoff_cnt = cnt;

endmodule
`default_nettype wire

// File: tb/tb_trigger_holdoff_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_trigger_holdoff_ctrl
// Brief   : Directed self-checking bench for trigger_holdoff_ctrl
// Revision: 1.0
// ============================================================================
module tb_trigger_holdoff_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        primed;
    logic [7:0]  i_data, i_mask, i_value, i_edge_en;
    logic        i_force;
    logic [15:0] i_holdoff;
    logic        i_arm;
    logic        triggered, stopped;
    logic [1:0]  o_state;
    logic [15:0] o_holdoff_cnt;

    int errors = 0;
    int checks = 0;

    wire [19:0] obs = {o_state, triggered, stopped, o_holdoff_cnt};

    trigger_holdoff_ctrl #(
        .NUM_CH        (8),
        .HOLDOFF_WIDTH (16)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .primed        (primed),
        .i_data        (i_data),
        .i_mask        (i_mask),
        .i_value       (i_value),
        .i_edge_en     (i_edge_en),
        .i_force       (i_force),
        .i_holdoff     (i_holdoff),
        .i_arm         (i_arm),
        .triggered     (triggered),
        .stopped       (stopped),
        .o_state       (o_state),
        .o_holdoff_cnt (o_holdoff_cnt)
    );

    always #5 clk = ~clk;

    // Packs an expected {state, triggered, stopped, cnt} tuple.
    function automatic logic [19:0] exp_of(input logic [1:0] st, input logic t,
                                           input logic s, input logic [15:0] c);
        return {st, t, s, c};
    endfunction

    task automatic step(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; primed = 1'b0; i_data = 8'h00; i_mask = 8'h00;
        i_value = 8'h00; i_edge_en = 8'h00; i_force = 1'b0;
        i_holdoff = 16'd0; i_arm = 1'b0;
        step(2);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; primed = 1'b1; i_force = 1'b1; i_arm = 1'b1;
        i_data = 8'hFF; i_mask = 8'h00; i_value = 8'h00; i_edge_en = 8'h00;
        i_holdoff = 16'd7;
        step(2);
        checks++;
        if (obs !== exp_of(2'd0, 1'b0, 1'b0, 16'd0)) begin
            errors++; $display("FAIL reset_state: got %h exp %h", obs, exp_of(2'd0, 1'b0, 1'b0, 16'd0));
        end
        do_reset();
    endtask

    task automatic test_level();
        do_reset();
        i_mask = 8'h0F; i_value = 8'h05; i_edge_en = 8'h00; i_holdoff = 16'd3;
        i_data = 8'h00; primed = 1'b1;
        step(3);
        checks++;
        if (obs !== exp_of(2'd1, 1'b0, 1'b0, 16'd0)) begin
            errors++; $display("FAIL level_nomatch: got %h exp %h", obs, exp_of(2'd1, 1'b0, 1'b0, 16'd0));
        end
        i_data = 8'hA5;
        step();
        checks++;
        if (obs !== exp_of(2'd2, 1'b1, 1'b0, 16'd0)) begin
            errors++; $display("FAIL level_trig: got %h exp %h", obs, exp_of(2'd2, 1'b1, 1'b0, 16'd0));
        end
        step(3);
        checks++;
        if (obs !== exp_of(2'd2, 1'b1, 1'b0, 16'd3)) begin
            errors++; $display("FAIL level_cnt3: got %h exp %h", obs, exp_of(2'd2, 1'b1, 1'b0, 16'd3));
        end
        step();
        checks++;
        if (obs !== exp_of(2'd3, 1'b1, 1'b1, 16'd3)) begin
            errors++; $display("FAIL level_stop: got %h exp %h", obs, exp_of(2'd3, 1'b1, 1'b1, 16'd3));
        end
    endtask

    task automatic test_edge();
        do_reset();
        i_mask = 8'h01; i_value = 8'h01; i_edge_en = 8'h01; i_data = 8'h01;
        i_holdoff = 16'd4; primed = 1'b1;
        step(4);
        checks++;
        if (obs !== exp_of(2'd1, 1'b0, 1'b0, 16'd0)) begin
            errors++; $display("FAIL edge_held_high: got %h exp %h", obs, exp_of(2'd1, 1'b0, 1'b0, 16'd0));
        end
        i_data = 8'h00;
        step();
        checks++;
        if (obs !== exp_of(2'd1, 1'b0, 1'b0, 16'd0)) begin
            errors++; $display("FAIL edge_fall_vs_rise: got %h exp %h", obs, exp_of(2'd1, 1'b0, 1'b0, 16'd0));
        end
        i_data = 8'h01;
        step();
        checks++;
        if (obs !== exp_of(2'd2, 1'b1, 1'b0, 16'd0)) begin
            errors++; $display("FAIL edge_rise: got %h exp %h", obs, exp_of(2'd2, 1'b1, 1'b0, 16'd0));
        end

        do_reset();
        i_mask = 8'h01; i_value = 8'h00; i_edge_en = 8'h01; i_data = 8'h00;
        i_holdoff = 16'd4; primed = 1'b1;
        step(3);
        i_data = 8'h01;
        step();
        checks++;
        if (obs !== exp_of(2'd1, 1'b0, 1'b0, 16'd0)) begin
            errors++; $display("FAIL edge_rise_vs_fall: got %h exp %h", obs, exp_of(2'd1, 1'b0, 1'b0, 16'd0));
        end
        i_data = 8'h00;
        step();
        checks++;
        if (obs !== exp_of(2'd2, 1'b1, 1'b0, 16'd0)) begin
            errors++; $display("FAIL edge_fall: got %h exp %h", obs, exp_of(2'd2, 1'b1, 1'b0, 16'd0));
        end
    endtask

    task automatic test_gating();
        do_reset();
        i_mask = 8'h0F; i_value = 8'h05; i_data = 8'hA5; primed = 1'b0;
        step(3);
        checks++;
        if (obs !== exp_of(2'd0, 1'b0, 1'b0, 16'd0)) begin
            errors++; $display("FAIL gate_unprimed: got %h exp %h", obs, exp_of(2'd0, 1'b0, 1'b0, 16'd0));
        end
        i_data = 8'h00; primed = 1'b1;
        step();
        primed = 1'b0;
        step();
        checks++;
        if (obs !== exp_of(2'd0, 1'b0, 1'b0, 16'd0)) begin
            errors++; $display("FAIL gate_primed_drop: got %h exp %h", obs, exp_of(2'd0, 1'b0, 1'b0, 16'd0));
        end
        primed = 1'b1;
        step();
        primed = 1'b0; i_force = 1'b1;
        step();
        checks++;
        if (obs !== exp_of(2'd0, 1'b0, 1'b0, 16'd0)) begin
            errors++; $display("FAIL gate_primed_priority: got %h exp %h", obs, exp_of(2'd0, 1'b0, 1'b0, 16'd0));
        end
        i_force = 1'b0; i_mask = 8'hFF; i_value = 8'hFF; i_data = 8'h00;
        i_holdoff = 16'd5; primed = 1'b1;
        step(2);
        i_force = 1'b1;
        step();
        i_force = 1'b0;
        checks++;
        if (obs !== exp_of(2'd2, 1'b1, 1'b0, 16'd0)) begin
            errors++; $display("FAIL gate_force: got %h exp %h", obs, exp_of(2'd2, 1'b1, 1'b0, 16'd0));
        end
    endtask

    task automatic test_boundaries();
        do_reset();
        i_mask = 8'hFF; i_value = 8'hFF; primed = 1'b1; i_holdoff = 16'd0;
        step();
        i_force = 1'b1;
        step();
        checks++;
        if (obs !== exp_of(2'd2, 1'b1, 1'b0, 16'd0)) begin
            errors++; $display("FAIL h0_trig: got %h exp %h", obs, exp_of(2'd2, 1'b1, 1'b0, 16'd0));
        end
        step();
        checks++;
        if (obs !== exp_of(2'd3, 1'b1, 1'b1, 16'd0)) begin
            errors++; $display("FAIL h0_stop: got %h exp %h", obs, exp_of(2'd3, 1'b1, 1'b1, 16'd0));
        end
        step(2);
        checks++;
        if (obs !== exp_of(2'd3, 1'b1, 1'b1, 16'd0)) begin
            errors++; $display("FAIL stopped_ignores_fire: got %h exp %h", obs, exp_of(2'd3, 1'b1, 1'b1, 16'd0));
        end

        do_reset();
        i_mask = 8'hFF; i_value = 8'hFF; primed = 1'b1; i_holdoff = 16'hFFFF;
        step();
        i_force = 1'b1;
        step();
        i_force = 1'b0; i_holdoff = 16'd2;
        step(10);
        checks++;
        if (obs !== exp_of(2'd2, 1'b1, 1'b0, 16'd10)) begin
            errors++; $display("FAIL holdoff_change_ignored: got %h exp %h", obs, exp_of(2'd2, 1'b1, 1'b0, 16'd10));
        end
        step(65525);
        checks++;
        if (obs !== exp_of(2'd2, 1'b1, 1'b0, 16'hFFFF)) begin
            errors++; $display("FAIL hmax_last: got %h exp %h", obs, exp_of(2'd2, 1'b1, 1'b0, 16'hFFFF));
        end
        step();
        checks++;
        if (obs !== exp_of(2'd3, 1'b1, 1'b1, 16'hFFFF)) begin
            errors++; $display("FAIL hmax_stop: got %h exp %h", obs, exp_of(2'd3, 1'b1, 1'b1, 16'hFFFF));
        end
    endtask

    task automatic test_reset_rearm();
        do_reset();
        i_mask = 8'hFF; i_value = 8'hFF; primed = 1'b1; i_holdoff = 16'd10;
        step();
        i_force = 1'b1;
        step();
        i_force = 1'b0;
        step(5);
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++;
        if (obs !== exp_of(2'd0, 1'b0, 1'b0, 16'd0)) begin
            errors++; $display("FAIL reset_mid_holdoff: got %h exp %h", obs, exp_of(2'd0, 1'b0, 1'b0, 16'd0));
        end

        do_reset();
        i_mask = 8'hFF; i_value = 8'hFF; primed = 1'b1; i_holdoff = 16'd2;
        step();
        i_force = 1'b1;
        step();
        i_force = 1'b0; i_arm = 1'b1;
        step();
        checks++;
        if (obs !== exp_of(2'd2, 1'b1, 1'b0, 16'd1)) begin
            errors++; $display("FAIL arm_in_holdoff: got %h exp %h", obs, exp_of(2'd2, 1'b1, 1'b0, 16'd1));
        end
        i_arm = 1'b0;
        step(2);
        checks++;
        if (obs !== exp_of(2'd3, 1'b1, 1'b1, 16'd2)) begin
            errors++; $display("FAIL rearm_stop: got %h exp %h", obs, exp_of(2'd3, 1'b1, 1'b1, 16'd2));
        end
        i_arm = 1'b1;
        step();
        i_arm = 1'b0;
        checks++;
        if (obs !== exp_of(2'd0, 1'b0, 1'b0, 16'd0)) begin
            errors++; $display("FAIL rearm_idle: got %h exp %h", obs, exp_of(2'd0, 1'b0, 1'b0, 16'd0));
        end
        step();
        i_force = 1'b1;
        step();
        i_force = 1'b0;
        checks++;
        if (obs !== exp_of(2'd2, 1'b1, 1'b0, 16'd0)) begin
            errors++; $display("FAIL second_trigger: got %h exp %h", obs, exp_of(2'd2, 1'b1, 1'b0, 16'd0));
        end
    endtask

    initial begin
        test_reset();
        test_level();
        test_edge();
        test_gating();
        test_boundaries();
        test_reset_rearm();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
